// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit positions, TX state encoding and divisor helpers.
package wb_uart_tx_pkg;

    // Register offsets as decoded from adr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_LVL_LSB = 8;

    // Smallest baud divisor the transmitter can run with
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Divisors below the minimum are raised to the minimum
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        if (div < DIV_MIN) begin
            return DIV_MIN;
        end else begin
            return div;
        end
    endfunction

    // Squeeze a 9-bit level into the 8-bit STATUS field, saturating at 255
    function automatic logic [7:0] level_byte(input logic [8:0] lvl);
        if (lvl[8]) begin
            return 8'hFF;
        end else begin
            return lvl[7:0];
        end
    endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Pipelined Wishbone bus bundle used between the shared-bus interconnect
// and the UART transmitter slave.
interface wb_if;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output adr, dat_m, sel, cyc, stb, we,
        input  dat_s, ack, stall, err
    );

    modport slave (
        input  adr, dat_m, sel, cyc, stb, we,
        output dat_s, ack, stall, err
    );
endinterface

// File: rtl/wb_uart_tx_fifo.sv
// uart_tx_fifo: byte-wide synchronous FIFO with first-word-fall-through
// read port. A push while full is accepted only when a pop happens in the
// same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty = (level_r == '0);
    assign full  = (level_r == (AW+1)'(DEPTH));
    assign level = level_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify push/pop against the current occupancy
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-attached 8N1 UART transmitter (slave at 0x10001000).
// Build option: define WB_UART_TX_FIFO_EN to buffer bytes in a FIFO of
// FIFO_DEPTH entries; otherwise a single holding register is used.
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb,
    output logic tx,
    output logic irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic             bus_req_s;
    logic [1:0]       reg_sel_s;
    logic             push_req_s;
    logic             push_acc_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             div_wr_s;
    logic [15:0]      div_new_s;
    logic [31:0]      rd_data_s;
    logic             ack_r;
    logic [31:0]      dat_s_r;
    logic [15:0]      div_r;
    logic             ovf_r;

    // Buffer side
    logic             full_s;
    logic             empty_s;
    logic [LVL_W-1:0] level_s;
    logic [7:0]       buf_dout_s;

    // Transmitter side
    tx_state_e        state_r;
    tx_state_e        state_nxt_s;
    logic             pop_s;
    logic             bit_end_s;
    logic             tx_nxt_s;
    logic [15:0]      cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             irq_r;

    assign wb.ack   = ack_r;
    assign wb.dat_s = dat_s_r;
    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;
    assign tx       = tx_r;
    assign irq      = irq_r;

    assign bit_end_s = (cnt_r == 16'd0);

    // Decode the current bus cycle into register side effects
    always_comb begin
        bus_req_s  = wb.cyc && wb.stb;
        reg_sel_s  = wb.adr[3:2];
        push_req_s = bus_req_s && wb.we && (reg_sel_s == REG_TXDATA) && wb.sel[0];
        // A full buffer still takes the byte if the transmitter pops this cycle
        push_acc_s = push_req_s && (!full_s || pop_s);
        ovf_set_s  = push_req_s && full_s && !pop_s;
        ovf_clr_s  = bus_req_s && wb.we && (reg_sel_s == REG_STATUS) &&
                     wb.sel[0] && wb.dat_m[STAT_OVF];
        div_wr_s   = bus_req_s && wb.we && (reg_sel_s == REG_DIV) &&
                     (wb.sel[1] || wb.sel[0]);
        div_new_s  = {(wb.sel[1] ? wb.dat_m[15:8] : div_r[15:8]),
                      (wb.sel[0] ? wb.dat_m[7:0]  : div_r[7:0])};
    end

    // Read data multiplexer
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_STATUS: begin
                rd_data_s[STAT_BUSY]  = (state_r != TX_IDLE);
                rd_data_s[STAT_FULL]  = full_s;
                rd_data_s[STAT_EMPTY] = empty_s;
                rd_data_s[STAT_OVF]   = ovf_r;
                rd_data_s[STAT_LVL_LSB +: 8] = level_byte(9'(level_s));
            end
            REG_DIV:    rd_data_s = {16'h0000, div_r};
            REG_RSVD:   rd_data_s = 32'h0000_0000;
            default:    rd_data_s = 32'h0000_0000;
        endcase
    end

    // Bus acknowledge, read data and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r   <= 1'b0;
            dat_s_r <= 32'h0000_0000;
            div_r   <= clamp_div(16'(DEFAULT_DIV));
            ovf_r   <= 1'b0;
        end else begin
            ack_r   <= bus_req_s;
            dat_s_r <= (bus_req_s && !wb.we) ? rd_data_s : 32'h0000_0000;
            if (div_wr_s) begin
                div_r <= clamp_div(div_new_s);
            end
            // A new overflow in the same cycle outranks the clear
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef WB_UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc_s),
        .din   (wb.dat_m[7:0]),
        .pop   (pop_s),
        .dout  (buf_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );
`else
    logic       hold_valid_r;
    logic [7:0] hold_data_r;

    assign buf_dout_s = hold_data_r;
    assign full_s     = hold_valid_r;
    assign empty_s    = !hold_valid_r;
    assign level_s    = LVL_W'(hold_valid_r);

    // Single-entry holding register; refilled in the same cycle it is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
        end else if (push_acc_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= wb.dat_m[7:0];
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end
`endif

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // TX next-state logic; pops the buffer when a frame is about to start
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = TX_START;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    state_nxt_s = TX_DATA;
                end else begin
                    state_nxt_s = TX_START;
                end
            end
            TX_DATA: begin
                if (bit_end_s && (idx_r == 3'd7)) begin
                    state_nxt_s = TX_STOP;
                end else begin
                    state_nxt_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    if (!empty_s) begin
                        state_nxt_s = TX_START;
                        pop_s       = 1'b1;
                    end else begin
                        state_nxt_s = TX_IDLE;
                    end
                end else begin
                    state_nxt_s = TX_STOP;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                pop_s       = 1'b0;
            end
        endcase
    end

    // TX line level for the current state
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_r)
            TX_START: tx_nxt_s = 1'b0;
            TX_DATA:  tx_nxt_s = shift_r[0];
            TX_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Bit timer, bit index, shift register and registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            tx_r <= tx_nxt_s;
            if (pop_s) begin
                shift_r <= buf_dout_s;
                idx_r   <= 3'd0;
                cnt_r   <= div_r - 16'd1;
            end else if (state_r != TX_IDLE) begin
                if (bit_end_s) begin
                    // Reloading here makes a new DIV apply from the next bit
                    cnt_r <= div_r - 16'd1;
                    if (state_r == TX_DATA) begin
                        shift_r <= {1'b0, shift_r[7:1]};
                        idx_r   <= idx_r + 3'd1;
                    end
                end else begin
                    cnt_r <= cnt_r - 16'd1;
                end
            end
        end
    end

    // Drain-complete interrupt: buffer empty and transmitter idle
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b1;
        end else begin
            irq_r <= (state_r == TX_IDLE) && empty_s;
        end
    end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: TX FIFO entries, power of two, 2..256.
REQ-002 Parameter DEFAULT_DIV, default 868: reset value of the baud divisor, in clk cycles per bit.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wb  wb_if slave  -  pipelined Wishbone slave; 32-bit adr, dat_m, dat_s; 4-bit sel; cyc, stb, we, ack, stall, err.
REQ-006 tx  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-007 irq  output  1  level interrupt, high while FIFO empty and TX idle (drain complete).

Function
REQ-008 Register map, decoded from adr[3:2]: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 DIV (R/W), 0xC reads 0.
REQ-009 Slave SHALL assert ack exactly one cycle after each cycle with cyc&stb; stall and err held 0.
REQ-010 Back-to-back stb cycles SHALL each receive one ack, in order, with no lost transfers.
REQ-011 TXDATA write with sel[0]=1 SHALL push dat_m[7:0] into the FIFO; TXDATA reads return 0.
REQ-012 STATUS read fields: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO level.
REQ-013 Push while full SHALL drop the byte, set overflow, and still ack.
REQ-014 Writing 1 to STATUS bit 3 SHALL clear overflow; overflow set in the same cycle wins over the clear.
REQ-015 DIV[15:0] is R/W; written values below 2 SHALL be stored as 2; DIV[31:16] reads 0.
REQ-016 TX FSM states IDLE, START, DATA, STOP; IDLE->START pops the FIFO when non-empty, in the cycle after the pop becomes visible.
REQ-017 Each bit SHALL last exactly DIV clk cycles, from a down-counter loaded with DIV-1 and advancing at 0.
REQ-018 START drives 0; DATA shifts 8 bits LSB first under a 3-bit index; STOP drives 1.
REQ-019 From STOP: go to START if the FIFO is non-empty, else to IDLE; no idle gap between frames.
REQ-020 A DIV write mid-frame SHALL take effect at the next bit boundary.
REQ-021 Simultaneous push and pop SHALL leave the level unchanged; a push to a full FIFO in the pop cycle is accepted.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; level is $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-023 rst SHALL set: tx=1, ack=0, FSM=IDLE, FIFO empty, overflow=0, DIV=DEFAULT_DIV, irq=1 on the cycle after release.
REQ-024 rst asserted mid-frame SHALL abort the frame; tx=1 from the next edge, and queued bytes are discarded.

Configuration
REQ-025 With macro WB_UART_TX_FIFO_EN defined: FIFO of FIFO_DEPTH entries per REQ-011..022.
REQ-026 Without WB_UART_TX_FIFO_EN: single holding register (depth 1); full = holding register valid; FIFO_DEPTH ignored; level field 0 or 1.

Structure
REQ-027 Package wb_uart_tx_pkg SHALL hold register offsets, STATUS bit indices, the FSM state enum, and the minimum DIV constant.
REQ-028 Sub-module uart_tx_fifo (sync FIFO: push, pop, full, empty, level) SHALL be instantiated only under WB_UART_TX_FIFO_EN.
REQ-029 Block attaches as an additional slave on wb_interconnect_sharedbus at base 0x10001000, size 0x1000.

Verification
REQ-030 Reset, then write 0x55 to TXDATA with DIV=868: tx low for 868 cycles, then 1,0,1,0,1,0,1,0, then high; frame = 8680 cycles.
REQ-031 DIV=4, write 0xA5 then 0x3C back-to-back: two contiguous frames, 80 cycles total, no idle gap; irq rises after the final stop bit.
REQ-032 DIV=2, push 17 bytes with no pop window (FIFO_DEPTH 16): byte 17 dropped, STATUS[3]=1, level=16; W1C bit 3 -> 0.
REQ-033 Write 0 and 1 to DIV: both read back 2; write 0x1_0010: reads back 0x0010.
REQ-034 Assert rst mid-DATA: tx=1 next cycle, STATUS reads 0x04, irq=1; no residual frame after release.
REQ-035 Build without WB_UART_TX_FIFO_EN, push 2 bytes during frame 1: the second byte sets overflow only if the holding register is already valid.
